// File: rtl/fir_pkg.sv
// ============================================================================
// Module : fir_pkg
// Purpose: Shared definitions for the FIR tap chain and its output stages.
//          Holds the default datapath widths and the rounding/saturation
//          helper used to narrow a wide accumulator to an output sample.
// Ports  : none (package)
// Config : CONVERGENT_ROUND_EN - when defined, sat_round rounds half to even;
//          otherwise it rounds half up.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

  // Default widths shared by the tap chain and output stages.
  localparam int AW    = 40;   // accumulator width
  localparam int DW    = 16;   // output sample width
  localparam int SHIFT = 15;   // fractional bits discarded (Q15 taps)

  // Working width of the rounding helper. Accumulators up to CALC_W-2 bits
  // can have the rounding constant added without overflow.
  localparam int CALC_W = 64;
  // Widest output sample the helper can produce.
  localparam int DW_MAX = 32;

  typedef struct packed {
    logic [DW_MAX-1:0] data;  // result in the low dw bits, upper bits undefined
    logic              sat;   // result was clipped to the dw-bit range
  } sat_res_t;

  // Round 'value' by discarding 'shift' fractional bits, then clip it to a
  // signed 'dw'-bit range. 'value' must already be sign-extended to CALC_W.
  function automatic sat_res_t sat_round(input logic signed [CALC_W-1:0] value,
                                         input int                       shift,
                                         input int                       dw);
    logic signed [CALC_W-1:0] rnd;
    logic signed [CALC_W-1:0] shifted;
    logic signed [CALC_W-1:0] max_v;
    logic signed [CALC_W-1:0] min_v;
    sat_res_t                 res;

    res = '0;
    rnd = '0;
    if (shift > 0) begin
`ifdef CONVERGENT_ROUND_EN
      // Half-minus-one plus the LSB that survives the shift: exact ties
      // move up only when the surviving LSB is odd, landing on even.
      rnd = (64'sd1 <<< (shift - 1)) - 64'sd1
          + $signed({63'd0, value[shift[5:0]]});
`else
      rnd = 64'sd1 <<< (shift - 1);
`endif
    end

    shifted = (value + rnd) >>> shift;
    max_v   = (64'sd1 <<< (dw - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (dw - 1));

    if (shifted > max_v) begin
      res.data = max_v[DW_MAX-1:0];
      res.sat  = 1'b1;
    end else if (shifted < min_v) begin
      res.data = min_v[DW_MAX-1:0];
      res.sat  = 1'b1;
    end else begin
      res.data = shifted[DW_MAX-1:0];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_out_stage_if.sv
// ============================================================================
// Module : fir_out_stage_if
// Purpose: Valid/ready sample stream from the FIR output stage to the
//          bus/DMA side.
// Ports  : o_valid - sample available (stage -> consumer)
//          o_data  - signed DW-bit sample (stage -> consumer)
//          i_ready - consumer accepts sample (consumer -> stage)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fir_out_stage_if #(
  parameter int DW = fir_pkg::DW
);

  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;

  modport master (
    output o_valid,
    output o_data,
    input  i_ready
  );

  modport slave (
    input  o_valid,
    input  o_data,
    output i_ready
  );

endinterface

`default_nettype wire

// File: rtl/fir_out_fifo.sv
// ============================================================================
// Module : fir_out_fifo
// Purpose: Synchronous show-ahead FIFO. The head entry is visible on 'head'
//          whenever 'empty' is low; a pop consumes it at the clock edge.
//          Pointers carry one extra wrap bit so full and empty are told
//          apart by the MSB difference. No write-to-read bypass.
// Ports  : clk, rst       - clock, synchronous active-high reset
//          push, push_data- write request and data
//          pop            - consume head entry
//          head           - current head entry
//          full, empty    - occupancy flags
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4     // power of two, >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // When full, a write is legal only alongside a pop: the slot being
  // written is the head slot that the pop frees at the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage needs no reset; 'empty' masks whatever it holds.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

  assign head = mem[rd_ptr[PW-1:0]];

endmodule

`default_nettype wire

// File: rtl/fir_out_stage.sv
// ============================================================================
// Module : fir_out_stage
// Purpose: Output stage of the FIR accelerator. Decimates the final tap
//          accumulator, rounds and saturates it to a DW-bit sample, buffers
//          it in a small FIFO and presents it on a valid/ready stream.
//          Capture-to-valid latency is two clocks.
// Ports  : i_clk   - clock
//          i_reset - synchronous reset, active-high
//          i_ce    - sample strobe shared with the tap chain
//          i_acc   - signed AW-bit accumulator from the last tap
//          out     - sample stream (o_valid / o_data / i_ready)
//          o_sat   - sticky flag, any saturation since reset
//          o_drop  - one-cycle pulse, a result was discarded on a full FIFO
// Config : CONVERGENT_ROUND_EN - round half to even instead of half up.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_out_stage #(
  parameter int AW    = fir_pkg::AW,
  parameter int DW    = fir_pkg::DW,     // <= fir_pkg::DW_MAX
  parameter int SHIFT = fir_pkg::SHIFT,
  parameter int DECIM = 4,               // >= 1
  parameter int DEPTH = 4                // power of two, >= 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic signed [AW-1:0] i_acc,
  fir_out_stage_if.master      out,
  output logic                 o_sat,
  output logic                 o_drop
);

  import fir_pkg::*;

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  // --------------------------------------------------------------------------
  // Decimation: keep the strobe on which the counter reads zero, so the
  // first strobe after reset is always kept.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] dec_cnt;
  logic             keep;

  assign keep = i_ce && (dec_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dec_cnt <= '0;
    end else if (i_ce) begin
      dec_cnt <= (dec_cnt == CNT_W'(DECIM - 1)) ? '0 : dec_cnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: capture the kept accumulator. The valid flag follows 'keep'
  // every clock so a sample enters stage 2 exactly once.
  // --------------------------------------------------------------------------
  logic signed [AW-1:0] s1_acc;
  logic                 s1_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_acc   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= keep;
      if (keep) s1_acc <= i_acc;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: round, shift and clip, then write into the FIFO.
  // --------------------------------------------------------------------------
  sat_res_t      rnd_res;
  logic [DW-1:0] s2_data;
  logic          s2_sat;

  always_comb begin
    rnd_res = sat_round({{(CALC_W-AW){s1_acc[AW-1]}}, s1_acc}, SHIFT, DW);
    s2_data = rnd_res.data[DW-1:0];
    s2_sat  = rnd_res.sat;
  end

  generate
    if (DW < DW_MAX) begin : g_unused_hi
      logic unused_res_hi;
      assign unused_res_hi = ^rnd_res.data[DW_MAX-1:DW];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output FIFO and handshake
  // --------------------------------------------------------------------------
  logic [DW-1:0] fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          drop_now;

  assign pop = out.o_valid && out.i_ready;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign drop_now = s1_valid && fifo_full && !pop;

  fir_out_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_reset),
    .push      (s1_valid),
    .push_data (s2_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out.o_valid = !fifo_empty;
  assign out.o_data  = fifo_empty ? '0 : fifo_head;

  // --------------------------------------------------------------------------
  // Status flags. Saturation counts even if the sample is later dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_sat  <= 1'b0;
      o_drop <= 1'b0;
    end else begin
      if (s1_valid && s2_sat) o_sat <= 1'b1;
      o_drop <= drop_now;
    end
  end

endmodule

`default_nettype wire

// File: doc/fir_out_stage.md
Name: fir_out_stage

Overview:
- Downstream consumer of the FIR tap chain's final accumulator output.
- Decimates the accumulator stream, then rounds and saturates it to the output sample width.
- Buffers results in a small FIFO and presents them on a valid/ready stream to the bus/DMA side of the accelerator.
- Same clock-enable domain as the tap chain.

Parameters:
AW, 40, accumulator input width (matches tap-chain output width IW+TW+8)
DW, 16, output sample width, signed
SHIFT, 15, fractional bits discarded (Q15 taps)
DECIM, 4, decimation ratio, >=1
DEPTH, 4, output FIFO depth, power of two >=2

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_ce  in  1  sample strobe, same as tap chain i_ce
i_acc  in  AW  signed final accumulator from last tap
o_valid  out  1  output sample available
i_ready  in  1  downstream accepts sample
o_data  out  DW  signed rounded/saturated sample
o_sat  out  1  sticky: any saturation since reset
o_drop  out  1  one-cycle pulse: result discarded, FIFO full

Behaviour:
- Reset (sync, active-high, priority over all): o_valid=0, o_data=0, o_sat=0, o_drop=0, FIFO empty, decimation counter=0, pipeline valid flags=0. Reset mid-stream discards all buffered and in-flight samples.
- Decimation: a counter advances 0..DECIM-1 on each i_ce and wraps. i_acc is captured only when i_ce=1 and count==0. The first i_ce after reset is therefore kept, then every DECIM-th. With DECIM=1, every i_ce is kept.
- Stage 1 (capture cycle N): register i_acc; set s1_valid.
- Stage 2 (cycle N+1), arithmetic:
  - Sign-extend to AW+1 bits and add 2^(SHIFT-1); this is round-half-up.
  - Arithmetic shift right by SHIFT.
  - If the result > 2^(DW-1)-1, emit 0x7FFF (for DW=16). If < -2^(DW-1), emit 0x8000.
  - Either saturation sets o_sat, which holds until reset.
  - Write the result into the FIFO.
- FIFO: show-ahead. o_data is the head entry and o_valid = not empty. A write at N+1 gives o_valid=1 at N+2 when the FIFO was empty. End-to-end latency is 2 cycles.
- Pop occurs when o_valid & i_ready. o_data and o_valid must hold stable while o_valid & !i_ready.
- Full and write with no pop: the result is discarded and o_drop pulses for 1 cycle. FIFO contents are unchanged.
- Full with simultaneous pop and write: both are accepted, count is unchanged, no drop.
- Empty with write: no bypass; o_valid rises the next cycle.
- Read/write pointers are log2(DEPTH)+1 bits and wrap naturally. Full/empty are decoded from the MSB difference.
- i_ce low: stage 1 is not loaded and the counter holds. Stage 2, the FIFO and the handshake keep running every clock.

Optional Feature:
CONVERGENT_ROUND_EN
- Defined: round-half-to-even. Add 2^(SHIFT-1)-1 plus bit SHIFT of the unshifted value, then shift. Exact ties round to the even result.
- Undefined: round-half-up as above.
- Latency and all other behaviour are identical in both builds.

Decomposition:
- Shared package fir_pkg: default widths AW/DW/SHIFT as localparams, and a function sat_round(value, shift) returning the DW-bit result plus a sat flag. The tap chain and any future output stages share this package.
- One sub-module: fir_out_fifo, a parameterised sync show-ahead FIFO (width, depth). It provides full/empty/push/pop and drop-on-full is decided in the parent.

Test Plan:
- Rounding: DECIM=1, i_acc=16384 (0.5 LSB), i_ready=1 → o_data=1 two cycles after i_ce. With CONVERGENT_ROUND_EN → 0. i_acc=49152 → 2 in both builds.
- Saturation: i_acc=2^31 → o_data=0x7FFF and o_sat=1. Then i_acc=-2^31 → 0x8000. o_sat stays 1 until i_reset.
- Decimation: DECIM=4, i_ce every cycle, i_acc=k·32768 for k=0..11 → outputs 0, 4, 8 in order, exactly 3 samples.
- Backpressure: DECIM=1, i_ready=0, 6 kept samples → first 4 held in order, o_drop pulses on the 5th and 6th. Then i_ready=1 drains exactly 4 with o_data stable while stalled.
- Full with simultaneous pop/push: FIFO full, i_ready=1 in the same cycle as a write → no o_drop, occupancy stays 4, order preserved.
- Reset mid-operation: FIFO holding 3 samples, assert i_reset 1 cycle → o_valid=0 next cycle, counter restarts, so the next i_ce sample is kept.
